// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator memory arbiter: requester indices,
// FSM encoding and the packed-bus slicing helper.
package accel_pkg;

    localparam int REQ_FIR   = 0;
    localparam int REQ_MM    = 1;
    localparam int REQ_QSORT = 2;

    localparam int OWN_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Low bit of requester idx inside a packed bus of w-bit slices.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid index after rr_i, wrapping
// modulo N; rr_i itself has the lowest priority.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] rr_i,
    output logic [IW-1:0] grant_o,
    output logic          any_o
);

    logic [IW:0] idx_s;

    assign any_o = |valid_i;

    // Scan from the farthest index down so the nearest valid one wins.
    always_comb begin
        grant_o = '0;
        idx_s   = '0;
        for (int i = N; i >= 1; i--) begin
            idx_s = {1'b0, rr_i} + (IW+1)'(i);
            if (idx_s >= (IW+1)'(N)) begin
                idx_s = idx_s - (IW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (valid_i[idx_s[IW-1:0]]) begin
                grant_o = idx_s[IW-1:0];
            end else begin
                grant_o = grant_o;
            end
        end
    end

endmodule

// File: rtl/accel_mem_arbiter.sv
// Round-robin burst arbiter sharing one single-port SRAM between the FIR,
// matrix-multiply and quick-sort engines, with beat cap and idle timeout.
module accel_mem_arbiter
    import accel_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int IDLE_TMO  = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [OWN_W-1:0]          owner,
    output logic                      busy,
    output logic                      tmo_err
);

    localparam int BEAT_W = $clog2(MAX_BURST);
    localparam int TMO_W  = $clog2(IDLE_TMO + 1);

    logic [0:0]        state_q,    state_d;
    logic [OWN_W-1:0]  owner_q,    owner_d;
    logic [OWN_W-1:0]  rr_q,       rr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [TMO_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              tmo_err_q,  tmo_err_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic [OWN_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic [ADDR_W-1:0] addr_arr_s  [N_REQ];
    logic [DATA_W-1:0] wdata_arr_s [N_REQ];

    rr_pick #(
        .N  (N_REQ),
        .IW (OWN_W)
    ) u_rr_pick (
        .valid_i (req_valid),
        .rr_i    (rr_q),
        .grant_o (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // Unpack the per-requester address and write-data slices.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr_s[i]  = req_addr[slice_lo(i, ADDR_W) +: ADDR_W];
            wdata_arr_s[i] = req_wdata[slice_lo(i, DATA_W) +: DATA_W];
        end
    end

    // Grant FSM, memory port steering and burst/idle bookkeeping.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        beat_cnt_d  = beat_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        tmo_err_d   = tmo_err_q;
        rsp_valid_d = '0;
        req_ready   = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    owner_d    = pick_idx_s;
                    rr_d       = pick_idx_s;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (idle_cnt_q == TMO_W'(IDLE_TMO)) begin
                    // Stalled owner loses the grant; nothing reaches the SRAM this cycle.
                    tmo_err_d  = 1'b1;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    req_ready[owner_q] = 1'b1;
                    if (req_valid[owner_q]) begin
                        mem_en     = 1'b1;
                        mem_we     = req_we[owner_q];
                        mem_addr   = addr_arr_s[owner_q];
                        mem_wdata  = wdata_arr_s[owner_q];
                        idle_cnt_d = '0;
                        if (!req_we[owner_q]) begin
                            rsp_valid_d[owner_q] = 1'b1;
                        end else begin
                            rsp_valid_d = '0;
                        end
                        if (req_last[owner_q] || (beat_cnt_q == BEAT_W'(MAX_BURST - 1))) begin
                            beat_cnt_d = '0;
                            state_d    = ST_IDLE;
                        end else begin
                            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q + TMO_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset also drops any in-flight read response.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_q        <= OWN_W'(N_REQ - 1);
            beat_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            tmo_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            beat_cnt_q  <= beat_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            tmo_err_q   <= tmo_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= (|rsp_valid_q) ? mem_rdata : rsp_rdata_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = (|rsp_valid_q) ? mem_rdata : rsp_rdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q == ST_GRANT);
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Scoreboard bench for accel_mem_arbiter: per-requester beat queues, a shadow
// memory for expected read data and a behavioural SRAM on the memory port.
module tb_accel_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        logic          we;
        logic          last;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    logic            wb_clk_i, wb_rst_i;
    logic [N-1:0]    req_valid, req_we, req_last, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic            mem_en, mem_we, busy, tmo_err;
    logic [AW-1:0]   mem_addr;
    logic [1:0]      owner;

    logic [DW-1:0] sram   [1 << AW];
    logic [DW-1:0] shadow [1 << AW];
    beat_t         bq [N][$];
    exp_t          sb [$];
    int            acc_log [$];
    int            rsp_log [$];
    logic          busy_log [$];
    logic          tmo_log [$];
    logic [DW-1:0] last_rsp;
    int            n_checks = 0;
    int            n_fail   = 0;

    accel_mem_arbiter dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .busy      (busy),
        .tmo_err   (tmo_err)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Single-port SRAM with one-cycle read latency.
    always @(posedge wb_clk_i) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_beat(input int r, input logic we, input logic last,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        beat_t b;
        b.we = we; b.last = last; b.addr = a; b.data = d;
        bq[r].push_back(b);
    endtask

    task automatic clear_logs();
        acc_log.delete(); rsp_log.delete(); busy_log.delete(); tmo_log.delete();
    endtask

    // One clock: drive heads at negedge, observe 1ns later, advance to next negedge.
    task automatic step();
        logic [N-1:0] acc;
        int           a;
        beat_t        b;
        exp_t         e;
        for (int r = 0; r < N; r++) begin
            if (bq[r].size() > 0) begin
                b = bq[r][0];
                req_valid[r] = 1'b1; req_we[r] = b.we; req_last[r] = b.last;
                req_addr[r*AW +: AW] = b.addr; req_wdata[r*DW +: DW] = b.data;
            end else begin
                req_valid[r] = 1'b0; req_we[r] = 1'b0; req_last[r] = 1'b0;
                req_addr[r*AW +: AW] = '0; req_wdata[r*DW +: DW] = '0;
            end
        end
        #1;
        for (int r = 0; r < N; r++) begin
            if (rsp_valid[r]) begin
                rsp_log.push_back(acc_log.size());
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(r), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(r), 32'(e.id));
                    check("rsp_data", rsp_rdata, e.data);
                    last_rsp = rsp_rdata;
                end
            end
        end
        acc = req_valid & req_ready;
        check("accept_onehot", 32'($countones(acc) <= 1), 32'd1);
        check("mem_en", 32'(mem_en), 32'(acc != '0));
        a = -1;
        for (int r = 0; r < N; r++) begin
            if (acc[r]) begin
                a = r;
                b = bq[r].pop_front();
                check("mem_addr", 32'(mem_addr), 32'(b.addr));
                check("mem_we", 32'(mem_we), 32'(b.we));
                if (b.we) begin
                    check("mem_wdata", mem_wdata, b.data);
                    shadow[b.addr] = b.data;
                end else begin
                    e.id = r; e.data = shadow[b.addr];
                    sb.push_back(e);
                end
            end
        end
        acc_log.push_back(a);
        busy_log.push_back(busy);
        tmo_log.push_back(tmo_err);
        @(negedge wb_clk_i);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((bq[0].size() + bq[1].size() + bq[2].size() + sb.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
        for (int r = 0; r < N; r++) bq[r].delete();
        sb.delete();
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        clear_logs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rspv"},  32'(rsp_valid), 32'd0);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_mem"},   32'({mem_en, mem_we, mem_addr}), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_stat"},  32'({owner, busy, tmo_err}), 32'd0);
    endtask

    initial begin
        int exp_a;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]   = 32'(i) + 32'h90;
            shadow[i] = 32'(i) + 32'h90;
        end
        wb_rst_i = 1'b1;
        req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
        last_rsp = '0;
        #1;
        check_all_zero("reset");
        do_reset();

        // Single requester 1: four reads 0x010..0x013, data 0xA0..0xA3.
        for (int k = 0; k < 4; k++) push_beat(1, 1'b0, k == 3, 12'(16 + k), 32'd0);
        drain("t1_drain", 50);
        check("t1_no_ready_idle", 32'(acc_log[0]), 32'hFFFF_FFFF);
        for (int k = 1; k <= 4; k++) check("t1_accept", 32'(acc_log[k]), 32'd1);
        for (int k = 0; k < 4; k++) check("t1_rsp_cycle", 32'(rsp_log[k]), 32'(k + 2));
        check("t1_busy_last", 32'(busy_log[4]), 32'd1);
        check("t1_busy_drop", 32'(busy_log[5]), 32'd0);
        check("t1_last_data", last_rsp, 32'hA3);

        // All three requesters, three 2-beat read bursts each.
        do_reset();
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < N; r++)
                for (int k = 0; k < 2; k++)
                    push_beat(r, 1'b0, k == 1, 12'(12'h200 + r*16 + b*2 + k), 32'd0);
        drain("t2_drain", 100);
        for (int i = 0; i <= 26; i++) begin
            exp_a = (i == 0 || (i - 1) % 3 == 2) ? -1 : ((i - 1) / 3) % 3;
            check("t2_order", 32'(acc_log[i]), 32'(exp_a));
        end

        // Requester 2: 20 writes with no last, cut into 8/8/4 by the cap.
        do_reset();
        for (int k = 0; k < 20; k++) push_beat(2, 1'b1, 1'b0, 12'(12'h100 + k), 32'(k));
        drain("t3_drain", 100);
        for (int i = 0; i <= 22; i++) begin
            exp_a = (i == 0 || i == 9 || i == 18) ? -1 : 2;
            check("t3_order", 32'(acc_log[i]), 32'(exp_a));
        end
        for (int k = 0; k < 20; k++) check("t3_sram", sram[12'h100 + k], 32'(k));

        // Idle timeout: owner 0 stalls after one beat, requester 1 waits.
        do_reset();
        push_beat(0, 1'b0, 1'b0, 12'h030, 32'd0);
        push_beat(1, 1'b0, 1'b1, 12'h031, 32'd0);
        drain("t4_drain", 100);
        check("t4_first_owner", 32'(acc_log[1]), 32'd0);
        exp_a = 0;
        for (int i = 2; i <= 19; i++) if (acc_log[i] != -1) exp_a++;
        check("t4_no_access_idle", 32'(exp_a), 32'd0);
        check("t4_next_owner", 32'(acc_log[20]), 32'd1);
        check("t4_tmo_before", 32'(tmo_log[18]), 32'd0);
        check("t4_tmo_set", 32'(tmo_log[19]), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("t4_tmo_sticky", 32'(tmo_err), 32'd1);

        // Write-then-read through two requesters.
        do_reset();
        push_beat(0, 1'b1, 1'b1, 12'h020, 32'h0000_FFF6);
        push_beat(1, 1'b0, 1'b1, 12'h020, 32'd0);
        drain("t5_drain", 50);
        check("t5_wr_first", 32'(acc_log[1]), 32'd0);
        check("t5_rd_second", 32'(acc_log[3]), 32'd1);
        check("t5_rdata", last_rsp, 32'h0000_FFF6);

        // Reset pulsed the cycle after a read accept.
        do_reset();
        for (int k = 0; k < 4; k++) push_beat(1, 1'b0, k == 3, 12'(12'h040 + k), 32'd0);
        step();
        step();
        check("t6_accepted", 32'(acc_log[1]), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check_all_zero("t6_rst");
        for (int r = 0; r < N; r++) bq[r].delete();
        sb.delete();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        clear_logs();
        push_beat(2, 1'b0, 1'b1, 12'h050, 32'd0);
        push_beat(0, 1'b0, 1'b1, 12'h051, 32'd0);
        drain("t6_drain", 50);
        check("t6_first_owner", 32'(acc_log[1]), 32'd0);
        check("t6_rsp_count", 32'(rsp_log.size()), 32'd2);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_mem_arbiter.md
Name: accel_mem_arbiter

Overview:
- Round-robin arbiter sharing one single-port user-project SRAM between the FIR, matrix-multiply and quick-sort accelerator engines inside user_proj_example.
- Grants whole bursts with a per-burst beat cap and an idle-timeout release.
- Forwards read data back to the owning engine, so the engines never contend on the memory pins.
- Sits between the engine datapaths and the SRAM macro, clocked from the Wishbone clock.

Parameters:
N_REQ, 3, number of requesters (index 0 = fir, 1 = mm, 2 = qsort)
ADDR_W, 12, word address width
DATA_W, 32, data width
MAX_BURST, 8, maximum beats per grant (power of two, >=2)
IDLE_TMO, 16, cycles an owner may stall with req_valid low before grant is revoked

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset, asynchronous, active-high
req_valid  in  N_REQ  per-requester beat valid
req_we  in  N_REQ  per-requester write enable (1=write)
req_last  in  N_REQ  marks final beat of requester's burst
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
req_ready  out  N_REQ  beat accepted this cycle when valid&ready
rsp_valid  out  N_REQ  read data valid for requester i
rsp_rdata  out  DATA_W  read data, shared by all requesters, qualified by rsp_valid
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after mem_en&!mem_we
owner  out  2  current grant holder index (valid when busy)
busy  out  1  a grant is held
tmo_err  out  1  sticky: a grant was revoked by timeout

Behaviour:
- Reset (async, wb_rst_i=1):
  - state=IDLE; rr pointer=N_REQ-1, so requester 0 wins first.
  - All outputs 0.
  - Beat and idle counters 0.
  - Any in-flight read response is dropped; rsp_valid must not fire after reset deasserts.
- States:
  - IDLE: if any req_valid, select the first valid index scanning rr+1, rr+2, ... modulo N_REQ. Register owner, set rr=owner, go GRANT next cycle. Arbitration latency: 1 cycle; req_ready is never high in IDLE.
  - GRANT:
    - req_ready[owner]=1 (combinational, independent of req_valid); all other req_ready=0.
    - Accept = req_valid[owner] & req_ready[owner].
    - On accept: mem_en=1; mem_we/mem_addr/mem_wdata taken combinationally from the owner's slice; beat_cnt++.
    - Leave to IDLE after the accept where req_last[owner]=1, or where beat_cnt==MAX_BURST-1 (cap), whichever comes first.
    - A requester cut by the cap re-requests and is rearbitrated normally; it loses priority to other pending requesters.
- Idle timeout:
  - In GRANT, idle_cnt counts cycles with req_valid[owner]=0 and resets on any accept.
  - When idle_cnt reaches IDLE_TMO: go IDLE, set tmo_err=1 (sticky until reset), no memory access that cycle.
- Outputs outside an accept: mem_en=0; mem_we, mem_addr, mem_wdata driven 0.
- Read response:
  - A read accept at cycle t gives rsp_valid[owner_t]=1 at t+1 and rsp_rdata=mem_rdata at t+1.
  - The response goes to the owner at t, even if the grant has moved by t+1.
  - rsp_rdata holds its last value when no rsp_valid is set.
  - Writes produce no response.
- Back-to-back: a burst ending at cycle t leaves IDLE at t+1, and the new owner's first accept is at t+2 (one bubble by design).
- Simultaneous last and cap on the same beat: single exit, no double count.
- busy=1 exactly in GRANT; owner holds its value in IDLE.

Decomposition:
- Shared package accel_pkg holds: requester index constants REQ_FIR=0, REQ_MM=1, REQ_QSORT=2; state encoding IDLE/GRANT; slice helper widths.
- One sub-module: rr_pick, a combinational round-robin priority selector (inputs: valid vector, rr pointer; outputs: grant index, any). Reused by the future UART/Wishbone arbiters.

Test Plan:
- Single requester 1: 4 reads at 0x010-0x013 with last on beat 4, SRAM preloaded 0xA0..0xA3 -> first req_ready cycle 1 after valid; rsp_valid[1] with rdata 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; busy drops after beat 4.
- All three valid continuously with 2-beat bursts -> grant order 0,1,2,0,1,2; exactly one bubble cycle between bursts; no beat lost or duplicated.
- Requester 2 writes 20 beats with no last -> grant cut after 8 beats, re-granted for 8 then 4 beats; SRAM contents 0..19 correct.
- Requester 0 granted, then holds req_valid low for 16 cycles -> grant revoked, tmo_err=1, requester 1 (pending) granted next; tmo_err stays 1.
- Requester 0 writes 0x0000FFF6 to 0x020, then requester 1 reads 0x020 -> rsp_valid[1] with rdata 0x0000FFF6.
- wb_rst_i pulsed mid-burst, the cycle after a read accept -> all outputs 0 immediately; no rsp_valid after release; first grant goes to requester 0.
